// File: rtl/slot_game_ctrl.sv
// Slot-machine game controller: coin credit, N spinning BCD reels stopped one
// at a time, payout evaluation and a timed result display phase.
module slot_game_ctrl #(
    parameter int NUM_REELS    = 3,
    parameter int REEL_DIV     = 1000000,
    parameter int MAX_CREDIT   = 99,
    parameter int BET          = 1,
    parameter int PAIR_MULT    = 2,
    parameter int JACKPOT_MULT = 10,
    parameter int SHOW_CYCLES  = 50000000,
    localparam int CW          = $clog2(MAX_CREDIT + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   C_IN,
    input  logic                   GAME_START,
    input  logic                   STOP,
    output logic [4*NUM_REELS-1:0] REEL_DIGITS,
    output logic [CW-1:0]          CREDIT,
    output logic [1:0]             STATE,
    output logic                   WIN,
    output logic [CW-1:0]          WIN_AMOUNT
);

    // Credit arithmetic is carried 8 bits wider than the credit register so
    // that coin + payout can never wrap before saturation.
    localparam int AW = CW + 8;
    localparam int PW = (REEL_DIV * NUM_REELS > 1) ? $clog2(REEL_DIV * NUM_REELS) : 1;
    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SPIN = 2'd1;
    localparam logic [1:0] S_EVAL = 2'd2;
    localparam logic [1:0] S_SHOW = 2'd3;

    logic [1:0]                   state_q;
    logic [CW-1:0]                credit_q;
    logic [CW-1:0]                win_amount_q;
    logic                         win_q;
    logic [SW-1:0]                show_cnt;
    logic [4*NUM_REELS-1:0]       digits_q;
    logic [NUM_REELS-1:0]         spinning;
    logic [NUM_REELS-1:0][PW-1:0] presc;
    logic                         c_in_q;
    logic                         start_q;
    logic                         stop_q;

    logic                         coin_edge;
    logic                         start_edge;
    logic                         stop_edge;
    logic                         start_ok;
    logic                         eval_now;
    logic [AW-1:0]                pay;
    logic [AW-1:0]                credit_sum;
    logic [NUM_REELS-1:0]         stop_sel;

    // Clamp a wide credit value to the credit ceiling.
    function automatic logic [CW-1:0] sat_credit(input logic [AW-1:0] v);
        if (v > AW'(MAX_CREDIT)) return CW'(MAX_CREDIT);
        return v[CW-1:0];
    endfunction

    // Payout for a frozen reel pattern: jackpot beats the reel0/reel1 pair.
    function automatic logic [AW-1:0] payout(input logic [4*NUM_REELS-1:0] d);
        logic all_eq;
        all_eq = 1'b1;
        for (int i = 1; i < NUM_REELS; i++) begin
            if (d[4*i +: 4] != d[3:0]) all_eq = 1'b0;
        end
        if (all_eq) return AW'(BET * JACKPOT_MULT);
        if (d[7:4] == d[3:0]) return AW'(BET * PAIR_MULT);
        return '0;
    endfunction

    // One BCD step; even reels count up, odd reels count down.
    function automatic logic [3:0] next_digit(input logic [3:0] d, input logic up);
        if (up) return (d == 4'd9) ? 4'd0 : d + 4'd1;
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    assign coin_edge  = C_IN & ~c_in_q;
    assign start_edge = GAME_START & ~start_q;
    assign stop_edge  = STOP & ~stop_q;
    // Start is judged against the credit before any coin arriving on the same edge.
    assign start_ok   = (state_q == S_IDLE) && start_edge && (credit_q >= CW'(BET));
    assign eval_now   = (state_q == S_SPIN) && (spinning == '0);
    assign pay        = payout(digits_q);

    // Net credit change for this edge, computed wide before saturation.
    always_comb begin
        credit_sum = AW'(credit_q) + AW'(coin_edge);
        if (eval_now) credit_sum = credit_sum + pay;
        if (start_ok) credit_sum = credit_sum - AW'(BET);
    end

    // A STOP edge picks the lowest-indexed reel that is still spinning.
    always_comb begin
        stop_sel = '0;
        if (state_q == S_SPIN && stop_edge) stop_sel = spinning & (~spinning + NUM_REELS'(1));
    end

    // Input history for edge detection; held high in reset so a level that is
    // already high at release is not mistaken for a new press.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            c_in_q  <= 1'b1;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
        end else begin
            c_in_q  <= C_IN;
            start_q <= GAME_START;
            stop_q  <= STOP;
        end
    end

    // Game sequencing, credit bookkeeping and win reporting.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            credit_q     <= '0;
            win_q        <= 1'b0;
            win_amount_q <= '0;
            show_cnt     <= '0;
        end else begin
            credit_q <= sat_credit(credit_sum);
            win_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        win_amount_q <= '0;
                        state_q      <= S_SPIN;
                    end
                end
                S_SPIN: begin
                    if (eval_now) begin
                        win_amount_q <= sat_credit(pay);
                        win_q        <= (pay != '0);
                        state_q      <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    show_cnt <= '0;
                    state_q  <= S_SHOW;
                end
                S_SHOW: begin
                    if (show_cnt == SW'(SHOW_CYCLES - 1)) state_q <= S_IDLE;
                    else show_cnt <= show_cnt + SW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Reel prescalers and digits; a stop on a tick edge keeps the pre-tick digit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            digits_q <= '0;
            spinning <= '0;
            presc    <= '0;
        end else if (start_ok) begin
            spinning <= '1;
            presc    <= '0;
        end else if (state_q == S_SPIN) begin
            spinning <= spinning & ~stop_sel;
            for (int i = 0; i < NUM_REELS; i++) begin
                if (spinning[i]) begin
                    if (presc[i] == PW'(REEL_DIV * (i + 1) - 1)) begin
                        presc[i] <= '0;
                        if (!stop_sel[i])
                            digits_q[4*i +: 4] <= next_digit(digits_q[4*i +: 4], (i % 2) == 0);
                    end else begin
                        presc[i] <= presc[i] + PW'(1);
                    end
                end
            end
        end
    end

    assign REEL_DIGITS = digits_q;
    assign CREDIT      = credit_q;
    assign STATE       = state_q;
    assign WIN         = win_q;
    assign WIN_AMOUNT  = win_amount_q;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed + randomized bench for slot_game_ctrl with a timing-formula reel model.
module tb_slot_game_ctrl;

    localparam int NR    = 3;
    localparam int RDIV  = 2;
    localparam int SHOWC = 8;
    localparam int MAXC  = 99;

    logic        CLK = 1'b0;
    logic        RST;
    logic        C_IN;
    logic        GAME_START;
    logic        STOP;
    logic [11:0] REEL_DIGITS;
    logic [6:0]  CREDIT;
    logic [1:0]  STATE;
    logic        WIN;
    logic [6:0]  WIN_AMOUNT;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int m_credit;
    int m_dig[NR];

    slot_game_ctrl #(
        .NUM_REELS(NR), .REEL_DIV(RDIV), .SHOW_CYCLES(SHOWC)
    ) dut (
        .CLK(CLK), .RST(RST), .C_IN(C_IN), .GAME_START(GAME_START), .STOP(STOP),
        .REEL_DIGITS(REEL_DIGITS), .CREDIT(CREDIT), .STATE(STATE),
        .WIN(WIN), .WIN_AMOUNT(WIN_AMOUNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // Reel i, stopped r edges after the start edge, has seen one tick for
    // every full prescale period that elapsed strictly before the stop edge.
    function automatic int ticks(input int i, input int r);
        return (r - 1) / (RDIV * (i + 1));
    endfunction

    function automatic int digit_after(input int d0, input int i, input int n);
        if (i % 2 == 0) return (d0 + n) % 10;
        return (d0 - (n % 10) + 10) % 10;
    endfunction

    function automatic int pay_of(input int a, input int b, input int c);
        if (a == b && b == c) return 10;
        if (a == b) return 2;
        return 0;
    endfunction

    task automatic coin();
        C_IN = 1'b1;
        step();
        C_IN = 1'b0;
        m_credit = sat(m_credit + 1);
        chk("coin_credit", CREDIT, m_credit);
        step();
    endtask

    // mode 0: random stop times, 1: stop times chosen to hit targets,
    // 2: reel 0 stopped on its own tick edge, others random.
    task automatic run_game(input int mode, input int t0, input int t1, input int t2,
                            input bit coin_start, input bit coin_eval);
        int tgt[NR];
        int nd[NR];
        int k0, r, minr, p, packed_exp;
        tgt[0] = t0; tgt[1] = t1; tgt[2] = t2;
        GAME_START = 1'b1;
        if (coin_start) C_IN = 1'b1;
        step();
        k0 = cyc;
        GAME_START = 1'b0;
        C_IN = 1'b0;
        m_credit = sat(m_credit + (coin_start ? 1 : 0) - 1);
        chk("start_state", STATE, 1);
        chk("start_credit", CREDIT, m_credit);
        chk("start_win_amount", WIN_AMOUNT, 0);
        minr = 1;
        for (int i = 0; i < NR; i++) begin
            if (mode == 1) begin
                r = minr;
                while (digit_after(m_dig[i], i, ticks(i, r)) != tgt[i] && r < minr + 200) r++;
            end else if (mode == 2 && i == 0) begin
                r = 4;
            end else begin
                r = minr + $urandom_range(0, 9);
            end
            nd[i] = digit_after(m_dig[i], i, ticks(i, r));
            while (cyc < k0 + r - 1) step();
            STOP = 1'b1;
            step();
            STOP = 1'b0;
            chk("spin_state", STATE, 1);
            minr = r + 2;
        end
        if (coin_eval) C_IN = 1'b1;
        step();
        C_IN = 1'b0;
        p = pay_of(nd[0], nd[1], nd[2]);
        m_credit = sat(m_credit + p + (coin_eval ? 1 : 0));
        packed_exp = nd[0] + (nd[1] << 4) + (nd[2] << 8);
        chk("eval_state", STATE, 2);
        chk("eval_win", WIN, (p > 0) ? 1 : 0);
        chk("eval_win_amount", WIN_AMOUNT, p);
        chk("eval_credit", CREDIT, m_credit);
        chk("eval_digits", REEL_DIGITS, packed_exp);
        if (mode == 2) chk("tick_edge_hold", REEL_DIGITS[3:0], (m_dig[0] + 1) % 10);
        step();
        chk("show_state", STATE, 3);
        chk("show_win_cleared", WIN, 0);
        GAME_START = 1'b1;
        STOP = 1'b1;
        step();
        GAME_START = 1'b0;
        STOP = 1'b0;
        chk("show_start_ignored", STATE, 3);
        chk("show_credit_hold", CREDIT, m_credit);
        for (int j = 0; j < 6; j++) step();
        chk("show_last_cycle", STATE, 3);
        step();
        chk("show_to_idle", STATE, 0);
        chk("idle_digits_hold", REEL_DIGITS, packed_exp);
        chk("idle_win_amount_hold", WIN_AMOUNT, p);
        for (int i = 0; i < NR; i++) m_dig[i] = nd[i];
    endtask

    initial begin
        // Reset with every input high; release must not count as edges.
        RST = 1'b0; C_IN = 1'b1; GAME_START = 1'b1; STOP = 1'b1;
        m_credit = 0;
        for (int i = 0; i < NR; i++) m_dig[i] = 0;
        step(); step();
        chk("rst_digits", REEL_DIGITS, 0);
        chk("rst_credit", CREDIT, 0);
        chk("rst_state", STATE, 0);
        chk("rst_win", WIN, 0);
        chk("rst_win_amount", WIN_AMOUNT, 0);
        RST = 1'b1;
        step(); step(); step();
        chk("release_high_credit", CREDIT, 0);
        chk("release_high_state", STATE, 0);
        C_IN = 1'b0; GAME_START = 1'b0; STOP = 1'b0;
        step();
        chk("release_low_credit", CREDIT, 0);

        // Start with no credit is ignored.
        GAME_START = 1'b1;
        step();
        GAME_START = 1'b0;
        chk("nocredit_start_state", STATE, 0);
        step();
        chk("nocredit_start_state2", STATE, 0);

        // Coin and start on the same edge with one credit.
        coin();
        run_game(1, 1, 4, 7, 1'b1, 1'b0);
        chk("coinstart_credit", CREDIT, 1);

        // Jackpot 3,3,3 from four credits.
        coin(); coin(); coin();
        chk("credit_four", CREDIT, 4);
        run_game(1, 3, 3, 3, 1'b0, 1'b0);
        chk("jackpot_credit13", CREDIT, 13);

        // Pair and loss.
        run_game(1, 5, 5, 2, 1'b0, 1'b0);
        chk("pair_credit14", CREDIT, 14);
        run_game(1, 1, 4, 7, 1'b0, 1'b0);
        chk("loss_credit13", CREDIT, 13);

        // Randomized games, some with a coin landing on the payout edge.
        for (int g = 0; g < 5; g++) run_game(0, 0, 0, 0, 1'b0, 1'($urandom_range(0, 1)));
        run_game(1, 6, 6, 6, 1'b0, 1'b1);

        // Coin counting and saturation at the ceiling.
        for (int k = 0; k < 5; k++) coin();
        while (m_credit < MAXC) coin();
        coin();
        chk("credit_saturated", CREDIT, 99);

        // Lose four games to reach 95, then a jackpot saturates to 99.
        for (int g = 0; g < 4; g++) run_game(1, 1, 4, 7, 1'b0, 1'b0);
        chk("credit_95", CREDIT, 95);
        run_game(1, 8, 8, 8, 1'b0, 1'b0);
        chk("jackpot_sat_99", CREDIT, 99);

        // Reel 0 stopped exactly on its tick edge.
        run_game(2, 0, 0, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a spin.
        GAME_START = 1'b1;
        step();
        GAME_START = 1'b0;
        chk("midspin_state", STATE, 1);
        step(); step(); step();
        #2 RST = 1'b0;
        #1;
        chk("async_rst_digits", REEL_DIGITS, 0);
        chk("async_rst_credit", CREDIT, 0);
        chk("async_rst_state", STATE, 0);
        chk("async_rst_win", WIN, 0);
        chk("async_rst_win_amount", WIN_AMOUNT, 0);
        step();
        RST = 1'b1;
        m_credit = 0;
        step();
        chk("post_rst_state", STATE, 0);
        coin();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
